// File: rtl/cla_nibble_serial_ctrl_if.sv
// Bus bundle for cla_nibble_serial_ctrl: request handshake, result
// handshake, and the nibble-wide pins to the external 4-bit CLA slice.
//
// Handshake rule for both request (in_*) and result (out_*) channels:
// a transfer happens on a rising clk edge where valid && ready are both 1.
// The producer holds its payload stable while valid is high and not yet
// accepted.
// This controller never lowers out_valid without a transfer.
// in_ready does not depend combinationally on in_valid.
interface cla_nibble_serial_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf,
    output add_a, add_b, add_cin
  );

  // Requester / consumer / slice side.
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf,
    input  add_a, add_b, add_cin
  );
endinterface

// File: rtl/cla_nibble_serial_ctrl.sv
// Nibble-serial sequencer for a 4-bit carry-lookahead adder slice.
// A WIDTH-bit request is fed to the slice one nibble per cycle, LSB first.
// The carry is chained through a register, and the assembled sum is
// presented on a valid/ready result channel.
// Optional feature macro: CLA_SERIAL_OVF_EN. When it is defined, a signed
// overflow flag is computed. When it is undefined, out_ovf is tied to 0.
// dbg_state_o exposes the FSM state (0 IDLE, 1 RUN, 2 DONE).
module cla_nibble_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cla_nibble_serial_ctrl_if.slave  bus,
  output logic [1:0]               dbg_state_o
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  // Operands hold the nibbles not yet presented. They shift down by 4 bits
  // each RUN cycle.
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [3:0]       add_a_q;
  logic [3:0]       add_b_q;
  logic             add_cin_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             last_nib;

  assign last_nib = (idx_q == IW'(NIB - 1));

  // Main sequencer: accept, step through the nibbles, then hold the result
  // until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      add_a_q     <= 4'h0;
      add_b_q     <= 4'h0;
      add_cin_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Nibble 0 goes straight to the slice pins.
            // The remaining nibbles wait in op_*.
            add_a_q    <= bus.in_a[3:0];
            add_b_q    <= bus.in_b[3:0];
            add_cin_q  <= bus.in_cin;
            op_a_q     <= bus.in_a >> 4;
            op_b_q     <= bus.in_b >> 4;
            carry_q    <= bus.in_cin;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= bus.add_sum;
          carry_q             <= bus.add_cout;
          if (last_nib) begin
            idx_q       <= '0;
            add_a_q     <= 4'h0;
            add_b_q     <= 4'h0;
            add_cin_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q     <= idx_q + 1'b1;
            add_a_q   <= op_a_q[3:0];
            add_b_q   <= op_b_q[3:0];
            add_cin_q <= bus.add_cout;
            op_a_q    <= op_a_q >> 4;
            op_b_q    <= op_b_q >> 4;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLA_SERIAL_OVF_EN
  logic ovf_q;

  // Signed overflow is decided on the top nibble. The sign bits of A and B
  // are add_a_q[3] and add_b_q[3] in the final RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_nib) begin
      ovf_q <= (add_a_q[3] == add_b_q[3]) && (bus.add_sum[3] != add_a_q[3]);
    end else if (state_q == DONE && bus.out_ready) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign dbg_state_o   = state_q;

endmodule
